// File: rtl/win_pkg.sv
// Shared window definitions: tap indices and output-grid / coordinate sizing helpers
// used by the window generator, the convolution engine and the result writer.
package win_pkg;

    localparam int TAP11 = 0;
    localparam int TAP12 = 1;
    localparam int TAP13 = 2;
    localparam int TAP21 = 3;
    localparam int TAP22 = 4;
    localparam int TAP23 = 5;
    localparam int TAP31 = 6;
    localparam int TAP32 = 7;
    localparam int TAP33 = 8;

    function automatic int out_dim(input int size, input int stride);
        return (size - 3) / stride + 1;
    endfunction

    function automatic int coord_w(input int w, input int h);
        return $clog2((w > h) ? w : h);
    endfunction

endpackage

// File: rtl/line_buffer2.sv
// Two-row pixel history addressed by column: row1 is row r-1, row2 is row r-2.
// Combinational read, one write per accepted pixel; no flow control of its own.
module line_buffer2 #(
    parameter int N     = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wr_dat,
    output logic [N-1:0]  row1,
    output logic [N-1:0]  row2
);

    logic [N-1:0] mem_a [DEPTH];
    logic [N-1:0] mem_b [DEPTH];

    assign row1 = mem_a[addr];
    assign row2 = mem_b[addr];

    // Contents age by one row per write: the older row drops into mem_b.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_b[addr] <= mem_a[addr];
            mem_a[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/window3x3_stream.sv
// Raster pixel stream in, 3x3 windows with output coordinates out, one cycle after the completing pixel.
// A pixel is taken only when the output slot is free or being drained, so a stalled consumer stalls the input.
module window3x3_stream
    import win_pkg::*;
#(
    parameter int N      = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int STRIDE = 1,
    parameter int CW     = coord_w(IMG_W, IMG_H)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_pixel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9*N-1:0]  out_window,
    output logic [CW-1:0]   out_col,
    output logic [CW-1:0]   out_row,
    output logic            busy,
    output logic            frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int AW = $clog2(IMG_W);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] R_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO    = CW'(2);

    logic [1:0]          state;
    logic [CW-1:0]       r;
    logic [CW-1:0]       c;
    logic [CW-1:0]       rm2;
    logic [CW-1:0]       cm2;
    logic [8:0][N-1:0]   win_q;
    logic [8:0][N-1:0]   win_nxt;
    logic [N-1:0]        lb_row1;
    logic [N-1:0]        lb_row2;
    logic                accept;
    logic                last_px;
    logic                on_grid;
    logic                emit;

    assign in_ready   = (state == S_RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
    assign last_px    = (r == R_LAST) && (c == C_LAST);

    assign rm2 = r - TWO;
    assign cm2 = c - TWO;
    // With stride 2 only even offsets from the first full window land on the grid.
    assign on_grid = (STRIDE == 1) || (!rm2[0] && !cm2[0]);
    assign emit    = accept && (r >= TWO) && (c >= TWO) && on_grid;

    line_buffer2 #(
        .N     (N),
        .DEPTH (IMG_W),
        .AW    (AW)
    ) u_lb (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (c[AW-1:0]),
        .wr_dat (in_pixel),
        .row1   (lb_row1),
        .row2   (lb_row2)
    );

    always_comb begin
        win_nxt = win_q;
        for (int i = 0; i < 3; i++) begin
            win_nxt[3*i]     = win_q[3*i + 1];
            win_nxt[3*i + 1] = win_q[3*i + 2];
        end
        win_nxt[TAP13] = lb_row2;
        win_nxt[TAP23] = lb_row1;
        win_nxt[TAP33] = in_pixel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (c == C_LAST) begin
                            c <= '0;
                            r <= r + CW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                        if (last_px) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!out_valid || out_ready) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_col    <= '0;
            out_row    <= '0;
        end else begin
            if (accept) win_q <= win_nxt;
            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= win_nxt;
                out_col    <= (STRIDE == 2) ? (cm2 >> 1) : cm2;
                out_row    <= (STRIDE == 2) ? (rm2 >> 1) : rm2;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window3x3_stream.sv
// Three configurations (5x4 s1, 32x32 s1, 5x5 s2) driven one at a time and checked every cycle
// against a frame-level model that derives each window directly from the pixel array.
module tb_window3x3_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start_v;
    logic [2:0]       vld_v;
    logic [2:0]       rdy_v;
    logic [2:0]       in_ready_v;
    logic [2:0]       out_valid_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0][7:0]  pix_v;
    logic [2:0][71:0] win_v;
    logic [2:0]       col0, row0, col2, row2;
    logic [4:0]       col1, row1;

    window3x3_stream #(.N(8), .IMG_W(5), .IMG_H(4), .STRIDE(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(vld_v[0]), .in_ready(in_ready_v[0]),
        .in_pixel(pix_v[0]), .out_valid(out_valid_v[0]), .out_ready(rdy_v[0]), .out_window(win_v[0]),
        .out_col(col0), .out_row(row0), .busy(busy_v[0]), .frame_done(done_v[0]));

    window3x3_stream u_def (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(vld_v[1]), .in_ready(in_ready_v[1]),
        .in_pixel(pix_v[1]), .out_valid(out_valid_v[1]), .out_ready(rdy_v[1]), .out_window(win_v[1]),
        .out_col(col1), .out_row(row1), .busy(busy_v[1]), .frame_done(done_v[1]));

    window3x3_stream #(.N(8), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(vld_v[2]), .in_ready(in_ready_v[2]),
        .in_pixel(pix_v[2]), .out_valid(out_valid_v[2]), .out_ready(rdy_v[2]), .out_window(win_v[2]),
        .out_col(col2), .out_row(row2), .busy(busy_v[2]), .frame_done(done_v[2]));

    int img_w  [3] = '{5, 32, 5};
    int img_h  [3] = '{4, 32, 5};
    int stride [3] = '{1, 1, 2};
    int s2_t11 [4] = '{0, 2, 10, 12};
    int s2_col [4] = '{0, 1, 0, 1};
    int s2_row [4] = '{0, 0, 1, 1};

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;
    logic [7:0] pix [0:1023];

    // frame-level model state
    bit          m_active, m_flush, m_done, m_vld;
    logic [71:0] m_win;
    int          m_col, m_row, acc_n;

    // per-frame observations, cleared by the driver
    int          win_cnt, done_cnt;
    logic [71:0] first_w, last_w;
    int          first_c, first_r, last_c, last_r;
    int          t11_q[$], col_q[$], row_q[$];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    always @(negedge clk) begin : monitor
        logic [71:0] ow;
        int oc, orw, w, s, k, r, c;
        bit rdy, idle, nxt_done, exp_ir;
        w   = img_w[cur];
        s   = stride[cur];
        ow  = win_v[cur];
        oc  = (cur == 0) ? int'(col0) : (cur == 1) ? int'(col1) : int'(col2);
        orw = (cur == 0) ? int'(row0) : (cur == 1) ? int'(row1) : int'(row2);
        rdy = rdy_v[cur];
        if (!rst_n) begin
            check("reset_ctrl", {out_valid_v, in_ready_v, busy_v, done_v}, '0);
            check("reset_window", ow, '0);
            check("reset_coord", {oc, orw}, '0);
            m_active = 0; m_flush = 0; m_done = 0; m_vld = 0; acc_n = 0;
        end else begin
            exp_ir = m_active && (!m_vld || rdy);
            check("out_valid", out_valid_v[cur], m_vld);
            if (m_vld) begin
                check("window", ow, m_win);
                check("coord", {oc, orw}, {m_col, m_row});
            end
            check("in_ready", in_ready_v[cur], exp_ir);
            check("busy", busy_v[cur], m_active || m_flush || m_done);
            check("frame_done", done_v[cur], m_done);

            if (out_valid_v[cur] && rdy) begin
                win_cnt++;
                if (win_cnt == 1) begin first_w = ow; first_c = oc; first_r = orw; end
                last_w = ow; last_c = oc; last_r = orw;
                t11_q.push_back(int'(ow[7:0]));
                col_q.push_back(oc);
                row_q.push_back(orw);
            end
            if (done_v[cur]) done_cnt++;

            idle     = !m_active && !m_flush && !m_done;
            nxt_done = m_flush && (!m_vld || rdy);
            if (nxt_done) m_flush = 0;
            if (m_vld && rdy) m_vld = 0;
            if (vld_v[cur] && exp_ir) begin
                k = acc_n;
                acc_n++;
                r = k / w;
                c = k % w;
                if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
                    m_vld = 1;
                    m_col = (c - 2) / s;
                    m_row = (r - 2) / s;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            m_win[8*(3*i + j) +: 8] = pix[(r - 2 + i) * w + (c - 2 + j)];
                end
                if (k == w * img_h[cur] - 1) begin m_active = 0; m_flush = 1; end
            end
            if (start_v[cur] && idle) begin m_active = 1; acc_n = 0; end
            m_done = nxt_done;
        end
    end

    task automatic run_frame(input int d, input bit idx_pix, input int vld_pct, input int rdy_pct,
                             input bit stall, input int abort_at, input bit idle_poke);
        int total, sent, cyc, budget, stall_left;
        bit first_seen, acc, aborted;
        total = img_w[d] * img_h[d];
        budget = total * 20 + 200;
        for (int k = 0; k < total; k++) pix[k] = idx_pix ? 8'(k) : 8'($urandom);
        cur = d;
        win_cnt = 0; done_cnt = 0;
        t11_q.delete(); col_q.delete(); row_q.delete();
        @(posedge clk); #1;
        if (idle_poke) begin
            vld_v[d] = 1'b1;
            pix_v[d] = 8'hAA;
            repeat (3) @(posedge clk);
            #1 vld_v[d] = 1'b0;
        end
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        sent = 0; cyc = 0; stall_left = 0; first_seen = 0; aborted = 0;
        while (sent < total) begin
            if (abort_at > 0 && sent == abort_at) begin
                vld_v[d] = 1'b0;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                aborted = 1;
                break;
            end
            if (cyc >= budget) begin
                n_checks++; n_errors++;
                $display("FAIL feed_timeout: sent %0d required %0d", sent, total);
                break;
            end
            if (stall && !first_seen && out_valid_v[d]) begin first_seen = 1; stall_left = 5; end
            vld_v[d]   = ($urandom_range(99) < vld_pct);
            pix_v[d]   = pix[sent];
            start_v[d] = ($urandom_range(49) == 0);
            if (stall_left > 0) begin
                rdy_v[d] = 1'b0;
                stall_left--;
            end else begin
                rdy_v[d] = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            acc = vld_v[d] && in_ready_v[d];
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        start_v[d] = 1'b0;
        vld_v[d]   = 1'b0;
        if (!aborted) begin
            cyc = 0;
            while (busy_v[d] && cyc < 1000) begin
                rdy_v[d] = ($urandom_range(99) < rdy_pct);
                @(posedge clk); #1;
                cyc++;
            end
            if (busy_v[d]) begin
                n_checks++; n_errors++;
                $display("FAIL drain_timeout: busy %0b required 0", busy_v[d]);
            end
        end
        rdy_v[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        start_v = '0; vld_v = '0; rdy_v = '1; pix_v = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 5x4, pixels 0..19, free-running consumer, in_valid poked while idle
        run_frame(0, 1, 100, 100, 0, 0, 1);
        check("small_count", win_cnt, 6);
        check("small_first", first_w, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        check("small_first_xy", {first_c, first_r}, {32'd0, 32'd0});
        check("small_last", last_w, pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        check("small_last_xy", {last_c, last_r}, {32'd2, 32'd1});
        check("small_done", done_cnt, 1);

        // 32x32 defaults, pixel = index mod 256
        run_frame(1, 1, 100, 100, 0, 0, 0);
        check("def_count", win_cnt, 900);
        check("def_last_xy", {last_c, last_r}, {32'd29, 32'd29});
        check("def_last_tap33", last_w[71:64], 8'd255);
        check("def_done", done_cnt, 1);

        // 5x4 with a five-cycle consumer stall after the first window
        run_frame(0, 1, 100, 100, 1, 0, 0);
        check("stall_count", win_cnt, 6);
        check("stall_last", last_w, pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));

        // 5x5 stride 2
        run_frame(2, 1, 100, 100, 0, 0, 0);
        check("s2_count", win_cnt, 4);
        for (int i = 0; i < 4 && i < t11_q.size(); i++) begin
            check("s2_tap11", t11_q[i], s2_t11[i]);
            check("s2_xy", {col_q[i], row_q[i]}, {s2_col[i], s2_row[i]});
        end

        // random pixels and random handshakes on every configuration
        for (int n = 0; n < 3; n++) run_frame(0, 0, 70, 60, 0, 0, 0);
        for (int n = 0; n < 3; n++) run_frame(2, 0, 60, 70, 0, 0, 0);
        run_frame(1, 0, 85, 80, 0, 0, 0);
        check("rand_def_count", win_cnt, 900);

        // reset after 40 pixels, then a clean full frame
        run_frame(1, 0, 100, 100, 0, 40, 0);
        run_frame(1, 1, 90, 90, 0, 0, 0);
        check("post_reset_count", win_cnt, 900);
        check("post_reset_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
